syn_branch_resolver: RTL and testbench

- Resolve-side partner of the synchronous PC and branch history table (BHT).
- Each fetched instruction's prediction (PC, predicted next PC, BHT hit) is recorded in an in-order tracking queue.
- When EX reports the actual next PC, the head entry is popped and compared against it.
- Drives the PC/BHT update and redirect inputs (isbj, succeed, pc_before_g, g_addr), a pipeline flush, and the fetch stall on a full queue.

---
 rtl/syn_branch_resolver.sv | 193 +++++++++++++++++++
 tb/tb_syn_branch_resolver.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/syn_branch_resolver.sv
//==============================================================================
// Module   : syn_branch_resolver
// Purpose  : Resolve-side partner of the synchronous PC / BHT. Tracks each
//            fetched prediction in an in-order queue, compares the head entry
//            against the PC reported by EX, drives the BHT update / redirect
//            outputs, a timed pipeline flush and the fetch stall.
// Options  : BR_RESOLVER_STATS_EN adds saturating branch / mispredict counters.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef IM_ADDR_BIT
`define IM_ADDR_BIT 32
`endif

module syn_branch_resolver #(
   parameter int ADDR_W    = `IM_ADDR_BIT,
   parameter int DEPTH     = 4,
   parameter int FLUSH_CYC = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              f_valid,
   input  logic [ADDR_W-1:0] f_pc,
   input  logic [ADDR_W-1:0] f_pred,
   input  logic              f_hit,
   input  logic              r_valid,
   input  logic              r_isbj,
   input  logic [ADDR_W-1:0] r_next,
   output logic              isbj,
   output logic              succeed,
   output logic [ADDR_W-1:0] pc_before_g,
   output logic [ADDR_W-1:0] g_addr,
   output logic              flush,
`ifdef BR_RESOLVER_STATS_EN
   output logic [31:0]       stat_br,
   output logic [31:0]       stat_mis,
`endif
   output logic              f_full,
   output logic              q_err
);

   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = PW + 1;
   localparam int FCW = $clog2(FLUSH_CYC + 1);

   typedef enum logic [0:0] {
      S_RUN   = 1'b0,
      S_FLUSH = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [FCW-1:0]    flcnt_q, flcnt_d;

   logic [ADDR_W-1:0] pc_q   [DEPTH];
   logic [ADDR_W-1:0] pred_q [DEPTH];
   logic              hit_q  [DEPTH];
   logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q;

   logic              isbj_q, succeed_q, flush_q, qerr_q;
   logic [ADDR_W-1:0] pcbg_q, gaddr_q;

   logic              w_run, w_full, w_pop, w_mis, w_mis_pop, w_push, w_qerr_set;
   // The BHT hit bit travels with its entry but the resolve decision uses only
   // the full-width predicted PC, so it is not consumed here.
   logic              w_unused_hit;

   // Queue control decoded from the current state and the head entry
   always_comb begin
      w_run        = (state_q == S_RUN);
      w_full       = (count_q == CW'(DEPTH));
      w_pop        = r_valid & (count_q != '0) & w_run;
      w_mis        = (pred_q[rd_ptr_q] != r_next);
      w_mis_pop    = w_pop & w_mis;
      w_push       = f_valid & (~w_full | w_pop) & w_run & ~w_mis_pop;
      w_qerr_set   = r_valid & (count_q == '0) & w_run;
      w_unused_hit = hit_q[rd_ptr_q];
   end

   // FSM next state: a mispredict enters FLUSH for FLUSH_CYC enabled cycles
   always_comb begin
      state_d = state_q;
      flcnt_d = flcnt_q;
      case (state_q)
         S_RUN: begin
            if (w_mis_pop) begin
               state_d = S_FLUSH;
               flcnt_d = FCW'(FLUSH_CYC);
            end
         end
         S_FLUSH: begin
            if (flcnt_q == FCW'(1)) begin
               state_d = S_RUN;
            end else begin
               flcnt_d = flcnt_q - FCW'(1);
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_RUN;
         flcnt_q <= '0;
      end else if (en) begin
         state_q <= state_d;
         flcnt_q <= flcnt_d;
      end
   end

   // Entry storage, written at the tail on an accepted push
   always_ff @(posedge clk) begin
      if (en && rst_n && w_push) begin
         pc_q[wr_ptr_q]   <= f_pc;
         pred_q[wr_ptr_q] <= f_pred;
         hit_q[wr_ptr_q]  <= f_hit;
      end
   end

   // Pointers and occupancy; a mispredict pop empties the whole queue
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (en) begin
         if (w_mis_pop) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (w_push && !w_pop)      count_q <= count_q + CW'(1);
            else if (!w_push && w_pop) count_q <= count_q - CW'(1);
         end
      end
   end

   // Registered resolve outputs: one-cycle pulse after each pop
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         isbj_q    <= 1'b0;
         succeed_q <= 1'b0;
         pcbg_q    <= '0;
         gaddr_q   <= '0;
         flush_q   <= 1'b0;
         qerr_q    <= 1'b0;
      end else if (en) begin
         isbj_q    <= w_pop & (r_isbj | w_mis);
         succeed_q <= w_pop & ~w_mis;
         if (w_pop) begin
            pcbg_q  <= pc_q[rd_ptr_q];
            gaddr_q <= r_next;
         end
         flush_q   <= (state_d == S_FLUSH);
         qerr_q    <= qerr_q | w_qerr_set;
      end
   end

`ifdef BR_RESOLVER_STATS_EN
   logic [31:0] stat_br_q, stat_mis_q;

   // Saturating branch and mispredict counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_br_q  <= '0;
         stat_mis_q <= '0;
      end else if (en) begin
         if (w_pop && r_isbj && (stat_br_q != '1))  stat_br_q  <= stat_br_q + 32'd1;
         if (w_mis_pop && (stat_mis_q != '1))       stat_mis_q <= stat_mis_q + 32'd1;
      end
   end

   assign stat_br  = stat_br_q;
   assign stat_mis = stat_mis_q;
`endif

   assign isbj        = isbj_q;
   assign succeed     = succeed_q;
   assign pc_before_g = pcbg_q;
   assign g_addr      = gaddr_q;
   assign flush       = flush_q;
   assign f_full      = w_full;
   assign q_err       = qerr_q;

endmodule

`default_nettype wire

// File: tb/tb_syn_branch_resolver.sv
//==============================================================================
// Module   : tb_syn_branch_resolver
// Purpose  : Directed self-checking bench for syn_branch_resolver with an
//            expected-result scoreboard for the resolve pulses.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_syn_branch_resolver;

   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst_n, en, f_valid, f_hit, r_valid, r_isbj;
   logic [AW-1:0] f_pc, f_pred, r_next;
   logic          isbj, succeed, flush, f_full, q_err;
   logic [AW-1:0] pc_before_g, g_addr;
`ifdef BR_RESOLVER_STATS_EN
   logic [31:0]   stat_br, stat_mis;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      logic          e_isbj;
      logic          e_succeed;
      logic [AW-1:0] e_pc;
      logic [AW-1:0] e_ga;
   } exp_t;

   exp_t exp_q[$];

   syn_branch_resolver #(.ADDR_W(AW), .DEPTH(4), .FLUSH_CYC(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .f_valid     (f_valid),
      .f_pc        (f_pc),
      .f_pred      (f_pred),
      .f_hit       (f_hit),
      .r_valid     (r_valid),
      .r_isbj      (r_isbj),
      .r_next      (r_next),
      .isbj        (isbj),
      .succeed     (succeed),
      .pc_before_g (pc_before_g),
      .g_addr      (g_addr),
      .flush       (flush),
`ifdef BR_RESOLVER_STATS_EN
      .stat_br     (stat_br),
      .stat_mis    (stat_mis),
`endif
      .f_full      (f_full),
      .q_err       (q_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock, then compare any resolve pulse against the scoreboard
   task automatic cyc();
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("isbj",        32'(isbj),        32'(e.e_isbj));
         chk("succeed",     32'(succeed),     32'(e.e_succeed));
         chk("pc_before_g", 32'(pc_before_g), 32'(e.e_pc));
         chk("g_addr",      32'(g_addr),      32'(e.e_ga));
      end else begin
         chk("no_pulse", 32'({isbj, succeed}), 32'd0);
      end
   endtask

   task automatic push(input logic [AW-1:0] pc, input logic [AW-1:0] pred);
      f_valid = 1'b1;
      f_pc    = pc;
      f_pred  = pred;
      f_hit   = (pred != pc + AW'(1));
      cyc();
      f_valid = 1'b0;
   endtask

   // Resolve; when a pop is expected the head pc/pred give the expected pulse
   task automatic resolve(input logic rb, input logic [AW-1:0] nxt, input logic exp_pop,
                          input logic [AW-1:0] hpc, input logic [AW-1:0] hpred);
      exp_t e;
      r_valid = 1'b1;
      r_isbj  = rb;
      r_next  = nxt;
      if (exp_pop) begin
         e.e_isbj    = rb | (hpred != nxt);
         e.e_succeed = (hpred == nxt);
         e.e_pc      = hpc;
         e.e_ga      = nxt;
         exp_q.push_back(e);
      end
      cyc();
      r_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; f_valid = 1'b0; f_hit = 1'b0;
      r_valid = 1'b0; r_isbj = 1'b0;
      f_pc = '0; f_pred = '0; r_next = '0;

      // Reset then idle
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();
      chk("rst_pc_before_g", 32'(pc_before_g), 32'd0);
      chk("rst_g_addr",      32'(g_addr),      32'd0);
      chk("rst_flush",       32'(flush),       32'd0);
      chk("rst_f_full",      32'(f_full),      32'd0);
      chk("rst_q_err",       32'(q_err),       32'd0);

      // Correct prediction on a non-branch
      push(16'd5, 16'd6);
      resolve(1'b0, 16'd6, 1'b1, 16'd5, 16'd6);
      chk("ok_flush", 32'(flush), 32'd0);

      // Branch mispredict with a younger entry in flight
      push(16'd8, 16'd9);
      push(16'd9, 16'd10);
      resolve(1'b1, 16'd20, 1'b1, 16'd8, 16'd9);
      chk("mis_flush_c1", 32'(flush), 32'd1);
      resolve(1'b1, 16'd10, 1'b0, 16'd0, 16'd0);
      chk("mis_flush_c2", 32'(flush), 32'd1);
      cyc();
      chk("mis_flush_end", 32'(flush),  32'd0);
      chk("mis_empty",     32'(f_full), 32'd0);
      // The discarded entry (pc 9) must not resurface at the head
      push(16'd30, 16'd31);
      resolve(1'b0, 16'd31, 1'b1, 16'd30, 16'd31);

      // Fill, drop a push while full, then push+pop and drain across the wrap
      for (int i = 0; i < 4; i++) push(AW'(40 + i), AW'(41 + i));
      chk("full_set", 32'(f_full), 32'd1);
      push(16'd44, 16'd45);
      chk("full_hold", 32'(f_full), 32'd1);
      f_valid = 1'b1; f_pc = 16'd45; f_pred = 16'd46;
      resolve(1'b0, 16'd41, 1'b1, 16'd40, 16'd41);
      chk("full_pushpop", 32'(f_full), 32'd1);
      f_valid = 1'b1; f_pc = 16'd46; f_pred = 16'd47;
      resolve(1'b1, 16'd42, 1'b1, 16'd41, 16'd42);
      f_valid = 1'b1; f_pc = 16'd47; f_pred = 16'd48;
      resolve(1'b0, 16'd43, 1'b1, 16'd42, 16'd43);
      f_valid = 1'b0;
      chk("wrap_full", 32'(f_full), 32'd1);
      resolve(1'b1, 16'd44, 1'b1, 16'd43, 16'd44);
      resolve(1'b0, 16'd46, 1'b1, 16'd45, 16'd46);
      resolve(1'b1, 16'd47, 1'b1, 16'd46, 16'd47);
      resolve(1'b0, 16'd48, 1'b1, 16'd47, 16'd48);
      chk("drain_not_full", 32'(f_full), 32'd0);

      // Non-branch mispredict (aliasing) still redirects; reset mid-flush
      push(16'd50, 16'd51);
      resolve(1'b0, 16'd99, 1'b1, 16'd50, 16'd51);
      chk("alias_flush", 32'(flush), 32'd1);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      chk("midrst_flush", 32'(flush),  32'd0);
      chk("midrst_full",  32'(f_full), 32'd0);

      // Enable low: an empty-queue resolve is ignored
      en = 1'b0;
      resolve(1'b1, 16'd7, 1'b0, 16'd0, 16'd0);
      chk("en_low_q_err", 32'(q_err), 32'd0);
      en = 1'b1;

      // Empty resolve: sticky error, no pulse
      resolve(1'b1, 16'd7, 1'b0, 16'd0, 16'd0);
      chk("q_err_set", 32'(q_err), 32'd1);
      cyc();
      chk("q_err_sticky", 32'(q_err), 32'd1);

`ifdef BR_RESOLVER_STATS_EN
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push(AW'(100 + i), AW'(200 + i));
         resolve(1'b1, AW'(200 + i), 1'b1, AW'(100 + i), AW'(200 + i));
      end
      push(16'd110, 16'd111);
      resolve(1'b1, 16'd300, 1'b1, 16'd110, 16'd111);
      cyc();
      cyc();
      chk("stat_br",  stat_br,  32'd4);
      chk("stat_mis", stat_mis, 32'd1);
      force dut.stat_br_q  = 32'hFFFF_FFFF;
      force dut.stat_mis_q = 32'hFFFF_FFFF;
      #1;
      release dut.stat_br_q;
      release dut.stat_mis_q;
      push(16'd120, 16'd121);
      resolve(1'b1, 16'd400, 1'b1, 16'd120, 16'd121);
      cyc();
      cyc();
      chk("stat_br_sat",  stat_br,  32'hFFFF_FFFF);
      chk("stat_mis_sat", stat_mis, 32'hFFFF_FFFF);
`endif

      if (exp_q.size() != 0) chk("scoreboard_left", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
